// File: rtl/lfsr_sched_pkg.sv
// Shared types and constants for the lfsr time-share scheduler.
package lfsr_pkg;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        LOAD     = 2'd1,
        RUN      = 2'd2
    } lfsr_sched_state_t;

    localparam int LFSR_W = 8;

    // An all-zero seed locks an XOR lfsr at zero; this value replaces it.
    localparam logic [LFSR_W-1:0] LFSR_SEED_FIX = 'h1;

endpackage

// File: rtl/lfsr_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          any
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/lfsr_sched.sv
// Shares one external lfsr among N_REQ consumers: loads seed/taps, then grants
// round-robin with at least STEPS clocks between grants.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   UNSEEDED | after reset; no grants until a config is accepted
//   LOAD     | one cycle; lfsrTapEn high, lfsr takes seed and tap mask
//   RUN      | arbitration active, holdoff counter gates grants
module lfsr_sched
    import lfsr_pkg::*;
#(
    parameter int WIDTH = LFSR_W,
    parameter int N_REQ = 4,
    parameter int STEPS = 8
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             cfgValid,
    output logic             cfgReady,
    input  logic [WIDTH-1:0] cfgSeed,
    input  logic [WIDTH-1:0] cfgTaps,
    output logic             cfgErr,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] lfsrIn,
    output logic [WIDTH-1:0] lfsrTaps,
    output logic             lfsrTapEn,
    input  logic [WIDTH-1:0] lfsrOut
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(STEPS + 1);

    lfsr_sched_state_t state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              cfg_err_q, cfg_err_d;
    logic              tap_en_q, tap_en_d;
    logic [WIDTH-1:0]  lfsr_in_q, lfsr_in_d;
    logic [WIDTH-1:0]  lfsr_taps_q, lfsr_taps_d;

    logic              cfg_acc;
    logic              cfg_bad;
    logic              grant;
    logic              arb_any;
    logic [N_REQ-1:0]  arb_winner;
    logic [PW-1:0]     win_idx;
    logic [WIDTH-1:0]  seed_fix;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (arb_winner),
        .any    (arb_any)
    );

    assign cfgReady = (state_q != LOAD);
    assign cfg_bad  = cfgValid && cfgReady && (cfgTaps == '0);
    assign cfg_acc  = cfgValid && cfgReady && (cfgTaps != '0);
    assign grant    = (state_q == RUN) && (cnt_q == '0) && arb_any && !cfg_acc;
    assign seed_fix = (cfgSeed == '0) ? WIDTH'(LFSR_SEED_FIX) : cfgSeed;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_winner[i]) win_idx = PW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = '0;
        rdata_d     = rdata_q;
        cfg_err_d   = cfg_bad;
        tap_en_d    = cfg_acc;
        lfsr_in_d   = lfsr_in_q;
        lfsr_taps_d = lfsr_taps_q;

        case (state_q)
            UNSEEDED, RUN: if (cfg_acc) state_d = LOAD;
            LOAD:          state_d = RUN;
            default:       state_d = UNSEEDED;
        endcase

        // Holdoff is timed from the accept edge, so the first grant lands
        // STEPS edges after the lfsr has taken its seed.
        if (cfg_acc) begin
            lfsr_in_d   = seed_fix;
            lfsr_taps_d = cfgTaps;
            cnt_d       = CW'(STEPS);
        end else if (grant) begin
            gnt_d   = arb_winner;
            rdata_d = lfsrOut;
            cnt_d   = CW'(STEPS - 1);
            ptr_d   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
        end else if ((state_q != UNSEEDED) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q     <= UNSEEDED;
            cnt_q       <= '0;
            ptr_q       <= '0;
            gnt_q       <= '0;
            rdata_q     <= '0;
            cfg_err_q   <= 1'b0;
            tap_en_q    <= 1'b0;
            lfsr_in_q   <= '0;
            lfsr_taps_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            rdata_q     <= rdata_d;
            cfg_err_q   <= cfg_err_d;
            tap_en_q    <= tap_en_d;
            lfsr_in_q   <= lfsr_in_d;
            lfsr_taps_q <= lfsr_taps_d;
        end
    end

    assign gnt       = gnt_q;
    assign rdata     = rdata_q;
    assign cfgErr    = cfg_err_q;
    assign lfsrTapEn = tap_en_q;
    assign lfsrIn    = lfsr_in_q;
    assign lfsrTaps  = lfsr_taps_q;

endmodule

// File: tb/tb_lfsr_sched.sv
// Bench for lfsr_sched: external lfsr model plus a timing-based reference model.
module tb_lfsr_sched;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int STEPS = 8;

    logic             clock    = 1'b0;
    logic             resetN   = 1'b0;
    logic             cfgValid = 1'b0;
    logic             cfgReady;
    logic [WIDTH-1:0] cfgSeed  = '0;
    logic [WIDTH-1:0] cfgTaps  = '0;
    logic             cfgErr;
    logic [N_REQ-1:0] req      = '0;
    logic [N_REQ-1:0] gnt;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] lfsrIn;
    logic [WIDTH-1:0] lfsrTaps;
    logic             lfsrTapEn;
    logic [WIDTH-1:0] lfsrOut;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    lfsr_sched #(.WIDTH(WIDTH), .N_REQ(N_REQ), .STEPS(STEPS)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .cfgValid  (cfgValid),
        .cfgReady  (cfgReady),
        .cfgSeed   (cfgSeed),
        .cfgTaps   (cfgTaps),
        .cfgErr    (cfgErr),
        .req       (req),
        .gnt       (gnt),
        .rdata     (rdata),
        .lfsrIn    (lfsrIn),
        .lfsrTaps  (lfsrTaps),
        .lfsrTapEn (lfsrTapEn),
        .lfsrOut   (lfsrOut)
    );

    // External Galois lfsr, as the parent would wire it.
    logic [WIDTH-1:0] lfsr_st   = 8'h5A;
    logic [WIDTH-1:0] lfsr_mask = 8'hB8;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] m);
        return s[0] ? ((s >> 1) ^ m) : (s >> 1);
    endfunction

    always @(posedge clock) begin
        if (lfsrTapEn) begin
            lfsr_st   <= lfsrIn;
            lfsr_mask <= lfsrTaps;
        end else begin
            lfsr_st <= lfsr_next(lfsr_st, lfsr_mask);
        end
    end
    assign lfsrOut = lfsr_st;

    // Reference model: eligibility from edge numbers of the last accepted
    // config and the last grant, rather than from any state register.
    int               cyc      = 0;
    bit               seeded   = 1'b0;
    int               cfg_edge = -100;
    int               last_gnt = -100;
    int               ptr_m    = 0;
    logic [N_REQ-1:0] exp_gnt  = '0;
    logic [WIDTH-1:0] exp_rdata = '0;
    logic [WIDTH-1:0] exp_in   = '0;
    logic [WIDTH-1:0] exp_taps = '0;
    logic             exp_err  = 1'b0;
    logic             exp_tapen = 1'b0;

    always @(posedge clock) begin : ref_model
        bit rdy;
        bit acc;
        bit elig;
        int w;
        cyc++;
        if (!resetN) begin
            seeded    = 1'b0;
            cfg_edge  = -100;
            last_gnt  = -100;
            ptr_m     = 0;
            exp_gnt   = '0;
            exp_rdata = '0;
            exp_in    = '0;
            exp_taps  = '0;
            exp_err   = 1'b0;
            exp_tapen = 1'b0;
        end else begin
            rdy  = (cfg_edge != cyc - 1);
            acc  = cfgValid && rdy && (cfgTaps != 0);
            elig = seeded && !acc && (req != 0) &&
                   (cyc >= cfg_edge + 1 + STEPS) && (cyc >= last_gnt + STEPS);
            exp_gnt = '0;
            if (elig) begin
                w = -1;
                for (int k = 0; k < N_REQ; k++)
                    if (w < 0 && req[(ptr_m + k) % N_REQ]) w = (ptr_m + k) % N_REQ;
                exp_gnt   = N_REQ'(1 << w);
                ptr_m     = (w + 1) % N_REQ;
                exp_rdata = lfsr_st;
                last_gnt  = cyc;
            end
            exp_err   = cfgValid && rdy && (cfgTaps == 0);
            exp_tapen = acc;
            if (acc) begin
                exp_in   = (cfgSeed == 0) ? 8'h01 : cfgSeed;
                exp_taps = cfgTaps;
                seeded   = 1'b1;
                cfg_edge = cyc;
            end
        end
    end

    task automatic do_reset();
        resetN   = 1'b0;
        cfgValid = 1'b0;
        repeat (2) @(negedge clock);
        resetN = 1'b1;
    endtask

    task automatic cfg_pulse(input logic [WIDTH-1:0] seed, input logic [WIDTH-1:0] taps);
        cfgValid = 1'b1;
        cfgSeed  = seed;
        cfgTaps  = taps;
        @(negedge clock);
        cfgValid = 1'b0;
    endtask

    task automatic test_reset();
        int g_seen;
        req = '0;
        do_reset();
        n_checks++; if (gnt !== 4'h0)   $display("FAIL reset_gnt: got %h want 0", gnt);        else n_pass++;
        n_checks++; if (rdata !== 8'h0) $display("FAIL reset_rdata: got %h want 0", rdata);    else n_pass++;
        n_checks++; if (cfgErr !== 1'b0) $display("FAIL reset_cfgErr: got %b want 0", cfgErr); else n_pass++;
        n_checks++; if (lfsrTapEn !== 1'b0) $display("FAIL reset_tapEn: got %b want 0", lfsrTapEn); else n_pass++;
        n_checks++; if (lfsrIn !== 8'h0) $display("FAIL reset_lfsrIn: got %h want 0", lfsrIn); else n_pass++;
        n_checks++; if (lfsrTaps !== 8'h0) $display("FAIL reset_lfsrTaps: got %h want 0", lfsrTaps); else n_pass++;
        n_checks++; if (cfgReady !== 1'b1) $display("FAIL reset_cfgReady: got %b want 1", cfgReady); else n_pass++;
        req = 4'hF;
        g_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (gnt !== 4'h0) g_seen++;
        end
        n_checks++; if (g_seen != 0) $display("FAIL unseeded_no_grant: got %0d grants want 0", g_seen); else n_pass++;
    endtask

    task automatic test_first_grant();
        int t_cfg;
        int first;
        req = 4'b0001;
        cfg_pulse(8'hFF, 8'hB8);
        t_cfg = cyc;
        n_checks++; if (lfsrTapEn !== 1'b1) $display("FAIL load_tapEn: got %b want 1", lfsrTapEn); else n_pass++;
        n_checks++; if (lfsrIn !== 8'hFF) $display("FAIL load_lfsrIn: got %h want ff", lfsrIn); else n_pass++;
        n_checks++; if (lfsrTaps !== 8'hB8) $display("FAIL load_lfsrTaps: got %h want b8", lfsrTaps); else n_pass++;
        n_checks++; if (cfgReady !== 1'b0) $display("FAIL load_cfgReady: got %b want 0", cfgReady); else n_pass++;
        @(negedge clock);
        n_checks++; if (lfsrTapEn !== 1'b0) $display("FAIL load_tapEn_len: got %b want 0", lfsrTapEn); else n_pass++;
        n_checks++; if (lfsr_st !== 8'hFF) $display("FAIL lfsr_seeded: got %h want ff", lfsr_st); else n_pass++;
        n_checks++; if (cfgReady !== 1'b1) $display("FAIL run_cfgReady: got %b want 1", cfgReady); else n_pass++;
        first = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            n_checks++; if (gnt !== exp_gnt) $display("FAIL first_gnt_cycle%0d: got %h want %h", i, gnt, exp_gnt); else n_pass++;
            if (gnt != 0 && first < 0) begin
                first = cyc;
                n_checks++; if (gnt !== 4'b0001) $display("FAIL first_gnt_value: got %h want 1", gnt); else n_pass++;
                n_checks++; if (rdata !== exp_rdata) $display("FAIL first_rdata: got %h want %h", rdata, exp_rdata); else n_pass++;
                req = '0;
            end
        end
        n_checks++; if (first != t_cfg + 1 + STEPS) $display("FAIL first_gnt_edge: got %0d want %0d", first, t_cfg + 1 + STEPS); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [N_REQ-1:0] seq [5];
        logic [N_REQ-1:0] g_val [8];
        int               g_cyc [8];
        int               ng;
        int               t_cfg;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ng = 0;
        req = '0;
        do_reset();
        req = 4'hF;
        cfg_pulse(8'h3C, 8'hB8);
        t_cfg = cyc;
        repeat (44) begin
            @(negedge clock);
            n_checks++; if (gnt !== exp_gnt) $display("FAIL rr_gnt@%0d: got %h want %h", cyc, gnt, exp_gnt); else n_pass++;
            if (gnt != 0 && ng < 8) begin
                g_val[ng] = gnt;
                g_cyc[ng] = cyc;
                ng++;
                n_checks++; if (rdata !== exp_rdata) $display("FAIL rr_rdata@%0d: got %h want %h", cyc, rdata, exp_rdata); else n_pass++;
            end
        end
        n_checks++; if (ng < 5) $display("FAIL rr_count: got %0d grants want >=5", ng); else n_pass++;
        if (ng >= 5) begin
            n_checks++; if (g_cyc[0] != t_cfg + 1 + STEPS) $display("FAIL rr_first_edge: got %0d want %0d", g_cyc[0], t_cfg + 1 + STEPS); else n_pass++;
            for (int k = 0; k < 5; k++) begin
                n_checks++; if (g_val[k] !== seq[k]) $display("FAIL rr_seq%0d: got %h want %h", k, g_val[k], seq[k]); else n_pass++;
                if (k > 0) begin
                    n_checks++; if (g_cyc[k] - g_cyc[k-1] != STEPS) $display("FAIL rr_spacing%0d: got %0d want %0d", k, g_cyc[k] - g_cyc[k-1], STEPS); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_cfg_checks();
        int ng;
        cfg_pulse(8'h55, 8'h00);
        n_checks++; if (cfgErr !== 1'b1) $display("FAIL err_pulse: got %b want 1", cfgErr); else n_pass++;
        n_checks++; if (lfsrTapEn !== 1'b0) $display("FAIL err_no_tapEn: got %b want 0", lfsrTapEn); else n_pass++;
        n_checks++; if (lfsrTaps !== 8'hB8) $display("FAIL err_taps_kept: got %h want b8", lfsrTaps); else n_pass++;
        @(negedge clock);
        n_checks++; if (cfgErr !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", cfgErr); else n_pass++;
        ng = 0;
        repeat (20) begin
            @(negedge clock);
            n_checks++; if (gnt !== exp_gnt) $display("FAIL err_gnt@%0d: got %h want %h", cyc, gnt, exp_gnt); else n_pass++;
            if (gnt != 0) ng++;
        end
        n_checks++; if (ng < 2) $display("FAIL err_grants_continue: got %0d want >=2", ng); else n_pass++;
        cfg_pulse(8'h00, 8'hB8);
        n_checks++; if (lfsrIn !== 8'h01) $display("FAIL zero_seed_fix: got %h want 01", lfsrIn); else n_pass++;
        n_checks++; if (lfsrTapEn !== 1'b1) $display("FAIL zero_seed_tapEn: got %b want 1", lfsrTapEn); else n_pass++;
        n_checks++; if (cfgErr !== 1'b0) $display("FAIL zero_seed_err: got %b want 0", cfgErr); else n_pass++;
    endtask

    task automatic test_cfg_vs_grant();
        int ng;
        int g_last;
        int t_cfg;
        int nxt;
        logic [N_REQ-1:0] nxt_val;
        req = '0;
        do_reset();
        req = 4'hF;
        cfg_pulse(8'h81, 8'hB8);
        ng = 0;
        g_last = -1;
        for (int i = 0; i < 40 && ng < 2; i++) begin
            @(negedge clock);
            if (gnt != 0) begin
                ng++;
                g_last = cyc;
            end
        end
        n_checks++; if (ng != 2) $display("FAIL cvg_setup: got %0d grants want 2", ng); else n_pass++;
        repeat (STEPS - 1) @(negedge clock);
        cfg_pulse(8'h77, 8'h8E);
        t_cfg = cyc;
        n_checks++; if (t_cfg != g_last + STEPS) $display("FAIL cvg_align: got %0d want %0d", t_cfg, g_last + STEPS); else n_pass++;
        n_checks++; if (gnt !== 4'h0) $display("FAIL cvg_no_gnt: got %h want 0", gnt); else n_pass++;
        n_checks++; if (lfsrTapEn !== 1'b1) $display("FAIL cvg_reload: got %b want 1", lfsrTapEn); else n_pass++;
        nxt = -1;
        nxt_val = '0;
        for (int i = 0; i < 12 && nxt < 0; i++) begin
            @(negedge clock);
            if (gnt != 0) begin
                nxt = cyc;
                nxt_val = gnt;
                n_checks++; if (rdata !== exp_rdata) $display("FAIL cvg_rdata: got %h want %h", rdata, exp_rdata); else n_pass++;
            end
        end
        n_checks++; if (nxt != t_cfg + 1 + STEPS) $display("FAIL cvg_next_edge: got %0d want %0d", nxt, t_cfg + 1 + STEPS); else n_pass++;
        n_checks++; if (nxt_val !== 4'b0100) $display("FAIL cvg_ptr_kept: got %h want 4", nxt_val); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int ng;
        int first;
        int t_cfg;
        logic [N_REQ-1:0] first_val;
        req = 4'hF;
        repeat (5) @(negedge clock);
        resetN = 1'b0;
        @(negedge clock);
        n_checks++; if (gnt !== 4'h0) $display("FAIL mid_reset_gnt: got %h want 0", gnt); else n_pass++;
        n_checks++; if (rdata !== 8'h0) $display("FAIL mid_reset_rdata: got %h want 0", rdata); else n_pass++;
        n_checks++; if (cfgReady !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", cfgReady); else n_pass++;
        @(negedge clock);
        resetN = 1'b1;
        ng = 0;
        repeat (30) begin
            @(negedge clock);
            if (gnt != 0) ng++;
        end
        n_checks++; if (ng != 0) $display("FAIL post_reset_no_grant: got %0d want 0", ng); else n_pass++;
        cfg_pulse(8'h42, 8'hB8);
        t_cfg = cyc;
        first = -1;
        first_val = '0;
        for (int i = 0; i < 12 && first < 0; i++) begin
            @(negedge clock);
            if (gnt != 0) begin
                first = cyc;
                first_val = gnt;
            end
        end
        n_checks++; if (first != t_cfg + 1 + STEPS) $display("FAIL post_reset_edge: got %0d want %0d", first, t_cfg + 1 + STEPS); else n_pass++;
        n_checks++; if (first_val !== 4'b0001) $display("FAIL post_reset_ptr: got %h want 1", first_val); else n_pass++;
    endtask

    task automatic test_random();
        req = '0;
        do_reset();
        cfg_pulse(8'($urandom), 8'h8E);
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            n_checks++; if (gnt !== exp_gnt) $display("FAIL rnd_gnt@%0d: got %h want %h", cyc, gnt, exp_gnt); else n_pass++;
            n_checks++; if (rdata !== exp_rdata) $display("FAIL rnd_rdata@%0d: got %h want %h", cyc, rdata, exp_rdata); else n_pass++;
            n_checks++; if (cfgErr !== exp_err) $display("FAIL rnd_cfgErr@%0d: got %b want %b", cyc, cfgErr, exp_err); else n_pass++;
            n_checks++; if (lfsrTapEn !== exp_tapen) $display("FAIL rnd_tapEn@%0d: got %b want %b", cyc, lfsrTapEn, exp_tapen); else n_pass++;
            n_checks++; if (lfsrIn !== exp_in) $display("FAIL rnd_lfsrIn@%0d: got %h want %h", cyc, lfsrIn, exp_in); else n_pass++;
            n_checks++; if (lfsrTaps !== exp_taps) $display("FAIL rnd_lfsrTaps@%0d: got %h want %h", cyc, lfsrTaps, exp_taps); else n_pass++;
            n_checks++; if (cfgReady !== (cfg_edge != cyc)) $display("FAIL rnd_cfgReady@%0d: got %b want %b", cyc, cfgReady, (cfg_edge != cyc)); else n_pass++;
            req      = N_REQ'($urandom_range(0, 15));
            cfgValid = ($urandom_range(0, 29) == 0);
            cfgSeed  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            cfgTaps  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        end
        cfgValid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_round_robin();
        test_cfg_checks();
        test_cfg_vs_grant();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
